// File: rtl/apb_master_bridge.sv
// Single-slave APB4 initiator: turns a valid/ready command stream into
// setup/access/gap-sequenced APB transfers and returns a one-cycle response.
`timescale 1ns/1ps
module apb_master_bridge #(
    parameter int unsigned BUS_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned MAX_DIM    = 4,
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned MIN_IDLE   = 2
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [BUS_WIDTH-1:0]  cmd_wdata,
    input  logic [MAX_DIM-1:0]    cmd_strb,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [BUS_WIDTH-1:0]  pwdata,
    output logic [MAX_DIM-1:0]    pstrb,
    input  logic [BUS_WIDTH-1:0]  prdata,
    input  logic                  pready,
    input  logic                  pslverr,
    output logic                  rsp_valid,
    output logic [BUS_WIDTH-1:0]  rsp_rdata,
    output logic                  rsp_slverr,
    output logic                  rsp_timeout
);

    localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned GAP_W  = (MIN_IDLE > 1) ? $clog2(MIN_IDLE) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(MIN_IDLE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        GAP    = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   psel_q, psel_d;
    logic                   penable_q, penable_d;
    logic                   pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]  paddr_q, paddr_d;
    logic [BUS_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [MAX_DIM-1:0]     pstrb_q, pstrb_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [BUS_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_slverr_q, rsp_slverr_d;
    logic                   rsp_timeout_q, rsp_timeout_d;
    logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        pstrb_d       = pstrb_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_slverr_d  = rsp_slverr_q;
        rsp_timeout_d = rsp_timeout_q;
        wait_cnt_d    = wait_cnt_q;
        gap_cnt_d     = gap_cnt_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    state_d  = SETUP;
                    psel_d   = 1'b1;
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_write ? cmd_wdata : '0;
                    pstrb_d  = cmd_write ? cmd_strb : '0;
                end
            end
            SETUP: begin
                state_d    = ACCESS;
                penable_d  = 1'b1;
                wait_cnt_d = '0;
            end
            ACCESS: begin
                // pready wins over a timeout firing on the same edge
                if (pready) begin
                    state_d       = GAP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    gap_cnt_d     = '0;
                    rsp_valid_d   = 1'b1;
                    rsp_slverr_d  = pslverr;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = (!pwrite_q && !pslverr) ? prdata : '0;
                end else if ((TIMEOUT != 0) && (wait_cnt_q == WAIT_LAST)) begin
                    state_d       = GAP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    gap_cnt_d     = '0;
                    rsp_valid_d   = 1'b1;
                    rsp_slverr_d  = 1'b0;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                end else if (TIMEOUT != 0) begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
            wait_cnt_q    <= '0;
            gap_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            pstrb_q       <= pstrb_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_slverr_q  <= rsp_slverr_d;
            rsp_timeout_q <= rsp_timeout_d;
            wait_cnt_q    <= wait_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign pstrb       = pstrb_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_slverr  = rsp_slverr_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: a bench-side APB slave plus a transfer-level
// expectation model, with directed and randomized commands.
`timescale 1ns/1ps
module tb_apb_master_bridge;

    localparam int unsigned BW = 32;
    localparam int unsigned AW = 16;
    localparam int unsigned SW = 4;
    localparam int unsigned TO = 16;
    localparam int unsigned MI = 2;

    logic          pclk = 1'b0;
    logic          presetn;
    logic          cmd_valid, cmd_valid_z;
    logic          cmd_ready, cmd_ready_z;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [BW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_strb;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [BW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic [BW-1:0] prdata;
    logic          pready, pslverr;
    logic          rsp_valid, rsp_slverr, rsp_timeout;
    logic [BW-1:0] rsp_rdata;
    logic          z_psel, z_penable, z_pwrite;
    logic [AW-1:0] z_paddr;
    logic [BW-1:0] z_pwdata;
    logic [SW-1:0] z_pstrb;
    logic          z_rsp_valid, z_rsp_slverr, z_rsp_timeout;
    logic [BW-1:0] z_rsp_rdata;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_end_cyc = -1;
    int rsp_seen = 0;
    int rsp_exp = 0;

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc++;
    always @(negedge pclk) if (rsp_valid === 1'b1) rsp_seen++;

    apb_master_bridge #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW), .MAX_DIM(SW),
                        .TIMEOUT(TO), .MIN_IDLE(MI)) dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout)
    );

    // Second instance with the timeout disabled
    apb_master_bridge #(.BUS_WIDTH(BW), .ADDR_WIDTH(AW), .MAX_DIM(SW),
                        .TIMEOUT(0), .MIN_IDLE(MI)) dut_z (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid_z), .cmd_ready(cmd_ready_z), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .psel(z_psel), .penable(z_penable), .pwrite(z_pwrite), .paddr(z_paddr),
        .pwdata(z_pwdata), .pstrb(z_pstrb), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .rsp_valid(z_rsp_valid), .rsp_rdata(z_rsp_rdata),
        .rsp_slverr(z_rsp_slverr), .rsp_timeout(z_rsp_timeout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One command end to end; called at a negedge, returns at a negedge.
    task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [BW-1:0] wd,
                        input logic [SW-1:0] st, input int waits, input logic err,
                        input logic [BW-1:0] rd, input logic keep);
        logic          exp_to, b2b;
        int            n_acc, spins;
        logic [BW-1:0] exp_pw, exp_rd;
        logic [SW-1:0] exp_ps;
        b2b    = (cmd_valid === 1'b1);
        exp_to = (TO != 0) && (waits >= int'(TO));
        n_acc  = exp_to ? int'(TO) : waits + 1;
        exp_pw = wr ? wd : '0;
        exp_ps = wr ? st : '0;
        exp_rd = (wr || exp_to || err) ? '0 : rd;
        rsp_exp++;

        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_strb = st;
        pready = 1'b0; pslverr = 1'b0;
        spins = 0;
        while (cmd_ready !== 1'b1 && spins < 20) begin
            @(negedge pclk);
            spins++;
        end
        if (spins >= 20) begin
            chk("accept_wait", 64'(spins), 64'(0));
            cmd_valid = 1'b0;
            return;
        end
        @(negedge pclk);
        if (!keep) begin
            cmd_valid = 1'b0;
            cmd_addr  = AW'($urandom);
            cmd_wdata = $urandom;
            cmd_strb  = SW'($urandom);
            cmd_write = ~wr;
        end
        chk("setup_phase", 64'({psel, penable, cmd_ready}), 64'(3'b100));
        chk("setup_bus", 64'({pwrite, paddr, pwdata, pstrb}), 64'({wr, addr, exp_pw, exp_ps}));
        if (b2b && last_end_cyc >= 0)
            chk("b2b_idle_gap", 64'(cyc - last_end_cyc), 64'(MI + 1));

        for (int n = 1; n <= n_acc; n++) begin
            @(negedge pclk);
            chk("access_phase", 64'({psel, penable, rsp_valid}), 64'(3'b110));
            chk("access_hold", 64'({pwrite, paddr, pwdata, pstrb}), 64'({wr, addr, exp_pw, exp_ps}));
            if (!exp_to && n == waits + 1) begin
                pready = 1'b1; pslverr = err; prdata = rd;
            end else begin
                pready = 1'b0; pslverr = 1'b1; prdata = $urandom;
            end
        end

        @(negedge pclk);
        pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
        chk("end_bus_idle", 64'({psel, penable, cmd_ready}), 64'(0));
        chk("rsp_valid", 64'(rsp_valid), 64'(1));
        chk("rsp_fields", 64'({rsp_rdata, rsp_slverr, rsp_timeout}),
            64'({exp_rd, err && !exp_to, exp_to}));
        chk("gap_hold", 64'({pwrite, paddr, pwdata, pstrb}), 64'({wr, addr, exp_pw, exp_ps}));
        last_end_cyc = cyc;
        @(negedge pclk);
        chk("rsp_one_pulse", 64'({rsp_valid, psel, cmd_ready}), 64'(0));
    endtask

    initial begin
        int hits;
        logic kp;
        presetn = 1'b0; cmd_valid = 1'b0; cmd_valid_z = 1'b0; cmd_write = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
        prdata = '0; pready = 1'b0; pslverr = 1'b0;

        // Reset values
        repeat (3) @(negedge pclk);
        chk("reset_bus", 64'({psel, penable, pwrite, paddr, pwdata, pstrb}), 64'(0));
        chk("reset_rsp", 64'({rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout}), 64'(0));
        chk("reset_cmd_ready", 64'(cmd_ready), 64'(0));
        presetn = 1'b1;
        @(negedge pclk);
        chk("ready_after_reset", 64'(cmd_ready), 64'(1));

        // Directed transfers
        xfer(1'b1, 16'h0010, 32'h0000_00AA, 4'hF, 0, 1'b0, 32'h0, 1'b0);
        xfer(1'b0, 16'h0020, 32'hFFFF_FFFF, 4'hF, 3, 1'b0, 32'h1234_5678, 1'b0);
        xfer(1'b1, 16'h0030, 32'hDEAD_BEEF, 4'h5, 2, 1'b1, 32'h0BAD_F00D, 1'b0);
        xfer(1'b0, 16'h0034, 32'h0, 4'h0, 1, 1'b1, 32'h5555_AAAA, 1'b0);
        xfer(1'b0, 16'h0044, 32'h0, 4'h0, 16, 1'b0, 32'h7777_7777, 1'b0);
        xfer(1'b0, 16'h0048, 32'h0, 4'h0, 15, 1'b0, 32'h8888_1111, 1'b0);
        xfer(1'b1, 16'h004C, 32'hCAFE_0001, 4'h3, 40, 1'b1, 32'h0, 1'b0);

        // Back-to-back with cmd_valid held
        xfer(1'b1, 16'h0100, 32'h1111_1111, 4'h1, 0, 1'b0, 32'h0, 1'b1);
        xfer(1'b0, 16'h0104, 32'h0, 4'h0, 1, 1'b0, 32'h2222_2222, 1'b1);
        xfer(1'b1, 16'h0108, 32'h3333_3333, 4'hC, 0, 1'b0, 32'h0, 1'b0);

        // Randomized transfers
        for (int i = 0; i < 24; i++) begin
            kp = (i != 23) && ($urandom_range(0, 1) == 1);
            xfer(1'($urandom), AW'($urandom), $urandom, SW'($urandom),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(12, 20)) : int'($urandom_range(0, 4)),
                 ($urandom_range(0, 3) == 0), $urandom, kp);
        end

        // Reset during ACCESS
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0055;
        hits = 0;
        while (cmd_ready !== 1'b1 && hits < 20) begin
            @(negedge pclk);
            hits++;
        end
        @(negedge pclk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge pclk);
        chk("pre_reset_access", 64'({psel, penable}), 64'(2'b11));
        presetn = 1'b0;
        #1;
        chk("async_reset_bus", 64'({psel, penable, cmd_ready, rsp_valid}), 64'(0));
        hits = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            if (rsp_valid !== 1'b0 || psel !== 1'b0) hits++;
        end
        chk("reset_no_rsp", 64'(hits), 64'(0));
        presetn = 1'b1;
        @(negedge pclk);
        chk("ready_after_rerelease", 64'(cmd_ready), 64'(1));
        last_end_cyc = -1;
        xfer(1'b0, 16'h0060, 32'h0, 4'h0, 1, 1'b0, 32'hA5A5_5A5A, 1'b0);

        // Timeout disabled: waits far past 16 cycles, then completes
        cmd_valid_z = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0070; pready = 1'b0;
        hits = 0;
        while (cmd_ready_z !== 1'b1 && hits < 20) begin
            @(negedge pclk);
            hits++;
        end
        @(negedge pclk);
        cmd_valid_z = 1'b0;
        hits = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge pclk);
            if (z_rsp_valid !== 1'b0 || z_penable !== 1'b1 || z_psel !== 1'b1) hits++;
        end
        chk("no_timeout_wait", 64'(hits), 64'(0));
        pready = 1'b1; prdata = 32'hCAFE_F00D; pslverr = 1'b0;
        @(negedge pclk);
        pready = 1'b0;
        chk("no_timeout_rsp", 64'({z_rsp_valid, z_rsp_rdata, z_rsp_slverr, z_rsp_timeout, z_psel}),
            64'({1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0}));

        @(negedge pclk);
        chk("rsp_count", 64'(rsp_seen), 64'(rsp_exp));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
